// File: rtl/cache_arbiter_pkg.sv
// Shared types and widths for the I/D cache physical-memory arbiter.
package arbiter_types;

    localparam int ADDR_WIDTH = 16;
    localparam int LINE_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Round-robin pick; only meaningful when at least one side is requesting.
    function automatic grant_t rr_pick(input logic i_req, input logic d_req, input grant_t last);
        grant_t pick;
        if (i_req && d_req) begin
            pick = (last == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (i_req) begin
            pick = GRANT_I;
        end else begin
            pick = GRANT_D;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the two private cache pmem ports plus the shared physical-memory port.
// master: the environment (both caches and the memory); slave: the arbiter.
interface cache_arbiter_if;
    import arbiter_types::*;

    // I-cache side
    logic                  i_pmem_read;
    logic [ADDR_WIDTH-1:0] i_pmem_address;
    logic [LINE_WIDTH-1:0] i_pmem_rdata;
    logic                  i_pmem_resp;

    // D-cache side
    logic                  d_pmem_read;
    logic                  d_pmem_write;
    logic [ADDR_WIDTH-1:0] d_pmem_address;
    logic [LINE_WIDTH-1:0] d_pmem_wdata;
    logic [LINE_WIDTH-1:0] d_pmem_rdata;
    logic                  d_pmem_resp;

    // Shared physical-memory port
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport master (
        output i_pmem_read, i_pmem_address,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  i_pmem_rdata, i_pmem_resp,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  i_pmem_read, i_pmem_address,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output i_pmem_rdata, i_pmem_resp,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/cache_arbiter_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Count enabled events, sticking at the maximum value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache.
// One requester is granted at a time; its request is latched on the grant edge
// and driven onto the shared port until pmem_resp, which is passed straight
// back to the granted side. Ties are broken round-robin.
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_arbiter_if.slave       bus,
    output logic [CNT_WIDTH-1:0] i_grant_count,
    output logic [CNT_WIDTH-1:0] d_grant_count
);

    arb_state_t            state_q;
    arb_state_t            state_d;
    grant_t                last_grant_q;
    grant_t                grant_sel;
    logic                  grant_en;
    logic                  i_req;
    logic                  d_req;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic                  i_inc;
    logic                  d_inc;

    assign i_req     = bus.i_pmem_read;
    assign d_req     = bus.d_pmem_read | bus.d_pmem_write;
    assign grant_sel = rr_pick(i_req, d_req, last_grant_q);

    // Read data is broadcast; only the resp strobes are steered.
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;

    // State register; reset drops straight back to IDLE so strobes fall at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the granted request so later requester activity cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GRANT_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else if (grant_en) begin
            last_grant_q <= grant_sel;
            if (grant_sel == GRANT_I) begin
                addr_q  <= bus.i_pmem_address;
                wdata_q <= '0;
                write_q <= 1'b0;
            end else begin
                addr_q  <= bus.d_pmem_address;
                wdata_q <= bus.d_pmem_wdata;
                // A writeback takes priority when both D strobes are up.
                write_q <= bus.d_pmem_write;
            end
        end
    end

    // Arbitration, shared-port drive and resp routing.
    always_comb begin
        state_d          = state_q;
        grant_en         = 1'b0;
        i_inc            = 1'b0;
        d_inc            = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.i_pmem_resp  = 1'b0;
        bus.d_pmem_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                // A pmem_resp seen here belongs to nobody and is dropped.
                if (i_req || d_req) begin
                    grant_en = 1'b1;
                    state_d  = (grant_sel == GRANT_I) ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = addr_q;
                bus.pmem_wdata   = wdata_q;
                if (bus.pmem_resp) begin
                    bus.i_pmem_resp = 1'b1;
                    i_inc           = 1'b1;
                    state_d         = IDLE;
                end
            end
            SERVE_D: begin
                bus.pmem_read    = ~write_q;
                bus.pmem_write   = write_q;
                bus.pmem_address = addr_q;
                bus.pmem_wdata   = wdata_q;
                if (bus.pmem_resp) begin
                    bus.d_pmem_resp = 1'b1;
                    d_inc           = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_i_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (i_inc),
        .count (i_grant_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_d_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (d_inc),
        .count (d_grant_count)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus pushes expected transactions,
// a memory responder answers the shared port, and a monitor checks every resp.
module tb_cache_arbiter;
    import arbiter_types::*;

    localparam int CW = 4;
    localparam int LW = LINE_WIDTH;
    localparam int AW = ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] i_grant_count;
    logic [CW-1:0] d_grant_count;

    cache_arbiter_if bus();

    cache_arbiter #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .i_grant_count (i_grant_count),
        .d_grant_count (d_grant_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          side;   // 0 = I, 1 = D
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    logic [LW-1:0] mem_q[$];
    int            total = 0;
    int            bad   = 0;
    int            mem_lat = 3;
    int            stray_reqs = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic expect_txn(input logic side, input logic wr, input logic [AW-1:0] addr,
                              input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
        exp_t e;
        e.side = side; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        exp_q.push_back(e);
        mem_q.push_back(rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.i_pmem_read    = 1'b0;
        bus.i_pmem_address = '0;
        bus.d_pmem_read    = 1'b0;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_address = '0;
        bus.d_pmem_wdata   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        mem_lat = 3;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // side: 0 = I, 1 = D, 2 = either. Returns at posedge+1 after the resp edge.
    task automatic wait_resp(input int side, input string name);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if ((side != 1 && bus.i_pmem_resp) || (side != 0 && bus.d_pmem_resp)) found = 1'b1;
        end
        chk(name, LW'(found), LW'(1));
        tick();
    endtask

    // Memory model: answers a strobe after mem_lat cycles, one-cycle resp pulse.
    initial begin
        int wcnt;
        int stray_seen;
        wcnt = 0;
        stray_seen = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bus.pmem_resp = 1'b0;
                wcnt = 0;
            end else if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
            end else if (stray_reqs != stray_seen) begin
                stray_seen++;
                bus.pmem_resp = 1'b1;
            end else if (bus.pmem_read || bus.pmem_write) begin
                wcnt++;
                if (wcnt >= mem_lat) begin
                    wcnt = 0;
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = (mem_q.size() > 0) ? mem_q.pop_front() : '0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: every resp the DUT presents must match the next expected transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (bus.i_pmem_resp || bus.d_pmem_resp)) begin
                chk("resp_exclusive", LW'(bus.i_pmem_resp & bus.d_pmem_resp), LW'(0));
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", LW'({bus.i_pmem_resp, bus.d_pmem_resp}), LW'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_side", LW'(bus.d_pmem_resp), LW'(e.side));
                    chk("resp_addr", LW'(bus.pmem_address), LW'(e.addr));
                    chk("resp_write", LW'(bus.pmem_write), LW'(e.wr));
                    chk("resp_read", LW'(bus.pmem_read), LW'(!e.wr));
                    if (e.wr) begin
                        chk("resp_wdata", bus.pmem_wdata, e.wdata);
                    end else begin
                        chk("resp_rdata_i", bus.i_pmem_rdata, e.rdata);
                        chk("resp_rdata_d", bus.d_pmem_rdata, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_reqs();

        // Reset state
        @(negedge clk);
        chk("rst_pmem_read", LW'(bus.pmem_read), LW'(0));
        chk("rst_pmem_write", LW'(bus.pmem_write), LW'(0));
        chk("rst_pmem_addr", LW'(bus.pmem_address), LW'(0));
        chk("rst_pmem_wdata", bus.pmem_wdata, LW'(0));
        chk("rst_resps", LW'({bus.i_pmem_resp, bus.d_pmem_resp}), LW'(0));
        chk("rst_counts", LW'({i_grant_count, d_grant_count}), LW'(0));
        chk("rst_rdata_bcast", bus.i_pmem_rdata, bus.pmem_rdata);

        // I-only read
        do_reset();
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h1230;
        expect_txn(1'b0, 1'b0, 16'h1230, '0, {8{16'hDEAD}});
        @(negedge clk);
        chk("i_strobe_before_grant", LW'(bus.pmem_read), LW'(0));
        @(negedge clk);
        chk("i_strobe_after_grant", LW'(bus.pmem_read), LW'(1));
        chk("i_addr_after_grant", LW'(bus.pmem_address), LW'(16'h1230));
        wait_resp(0, "i_only_resp");
        bus.i_pmem_read = 1'b0;
        @(negedge clk);
        chk("i_resp_one_cycle", LW'(bus.i_pmem_resp), LW'(0));
        chk("i_only_icount", LW'(i_grant_count), LW'(1));
        chk("i_only_dcount", LW'(d_grant_count), LW'(0));
        stray_reqs++;
        repeat (3) tick();
        chk("stray_icount", LW'(i_grant_count), LW'(1));
        chk("stray_dcount", LW'(d_grant_count), LW'(0));

        // D writeback (both D strobes high: write wins) then refill with no gap
        do_reset();
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 16'h4440;
        bus.d_pmem_wdata   = {16{8'hA5}};
        expect_txn(1'b1, 1'b1, 16'h4440, {16{8'hA5}}, '0);
        wait_resp(1, "d_wb_resp");
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 16'h8880;
        bus.d_pmem_wdata   = '0;
        expect_txn(1'b1, 1'b0, 16'h8880, '0, {4{32'h1111_2222}});
        @(negedge clk);
        chk("gap_idle_strobes", LW'({bus.pmem_read, bus.pmem_write}), LW'(0));
        @(negedge clk);
        chk("refill_strobe", LW'(bus.pmem_read), LW'(1));
        chk("refill_addr", LW'(bus.pmem_address), LW'(16'h8880));
        wait_resp(1, "d_refill_resp");
        bus.d_pmem_read = 1'b0;
        @(negedge clk);
        chk("wb_refill_dcount", LW'(d_grant_count), LW'(2));
        chk("wb_refill_icount", LW'(i_grant_count), LW'(0));

        // Simultaneous requests from reset, held continuously: I, D, I, D
        do_reset();
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h0010;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 16'h0020;
        expect_txn(1'b0, 1'b0, 16'h0010, '0, {4{32'hC0C0_0000}});
        expect_txn(1'b1, 1'b0, 16'h0020, '0, {4{32'hC0C0_0001}});
        expect_txn(1'b0, 1'b0, 16'h0010, '0, {4{32'hC0C0_0002}});
        expect_txn(1'b1, 1'b0, 16'h0020, '0, {4{32'hC0C0_0003}});
        for (int k = 0; k < 4; k++) wait_resp(2, "tie_resp");
        clear_reqs();
        @(negedge clk);
        chk("tie_icount", LW'(i_grant_count), LW'(2));
        chk("tie_dcount", LW'(d_grant_count), LW'(2));

        // Requester changes address and drops its request mid-service
        do_reset();
        mem_lat = 5;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 16'h0100;
        expect_txn(1'b1, 1'b0, 16'h0100, '0, {8{16'h0B0B}});
        @(negedge clk);
        @(negedge clk);
        tick();
        bus.d_pmem_address = 16'h0200;
        bus.d_pmem_read    = 1'b0;
        @(negedge clk);
        chk("midsvc_addr", LW'(bus.pmem_address), LW'(16'h0100));
        chk("midsvc_read", LW'(bus.pmem_read), LW'(1));
        wait_resp(1, "midsvc_resp");
        mem_lat = 3;
        @(negedge clk);
        chk("midsvc_dcount", LW'(d_grant_count), LW'(1));

        // Reset two cycles into SERVE_D
        do_reset();
        mem_lat = 20;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 16'h0300;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        bus.d_pmem_read = 1'b0;
        #1;
        chk("rst_mid_strobes", LW'({bus.pmem_read, bus.pmem_write}), LW'(0));
        chk("rst_mid_addr", LW'(bus.pmem_address), LW'(0));
        chk("rst_mid_resp", LW'({bus.i_pmem_resp, bus.d_pmem_resp}), LW'(0));
        chk("rst_mid_counts", LW'({i_grant_count, d_grant_count}), LW'(0));
        tick();
        reset   = 1'b0;
        mem_lat = 3;
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h0400;
        expect_txn(1'b0, 1'b0, 16'h0400, '0, {8{16'h4444}});
        wait_resp(0, "post_rst_resp");
        bus.i_pmem_read = 1'b0;
        @(negedge clk);
        chk("post_rst_icount", LW'(i_grant_count), LW'(1));
        chk("post_rst_dcount", LW'(d_grant_count), LW'(0));

        // Counter saturation: 17 I reads with a 4-bit counter
        do_reset();
        for (int k = 0; k < 17; k++) begin
            bus.i_pmem_read    = 1'b1;
            bus.i_pmem_address = AW'(16'h2000 + k * 16);
            expect_txn(1'b0, 1'b0, AW'(16'h2000 + k * 16), '0, {4{32'(32'h5A00_0000 + k)}});
            wait_resp(0, "sat_resp");
        end
        bus.i_pmem_read = 1'b0;
        @(negedge clk);
        chk("sat_icount", LW'(i_grant_count), LW'(15));
        stray_reqs++;
        repeat (3) tick();
        chk("sat_stray_icount", LW'(i_grant_count), LW'(15));
        chk("sat_stray_dcount", LW'(d_grant_count), LW'(0));

        repeat (3) tick();
        chk("queue_drained", LW'(exp_q.size()), LW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
